// File: rtl/activation_backprop_pkg.sv
// Shared activation definitions used by the forward activation and its backward mask.
// af_mask gives the derivative bit recorded for one forward sample.
package activation_backprop_pkg;

   typedef enum logic [1:0] {
      Identity = 2'd0,
      ReLu     = 2'd1,
      Sigmoid  = 2'd2,
      Tanh     = 2'd3
   } af_control;

   // ReLU passes the gradient only where the pre-activation was non-negative.
   function automatic logic af_mask(input af_control ctl, input logic sign);
      return (ctl == ReLu) ? ~sign : 1'b0;
   endfunction

endpackage

// File: rtl/activation_backprop_mask_fifo.sv
// 1-bit wide mask FIFO with synchronous clear and an occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module activation_backprop_mask_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       push_bit,
   input  logic                       pop,
   output logic                       pop_bit,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // NOTE: storage is not reset; only pointers and count are, so stale bits are never read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_bit;
   end

   // NOTE: all sequential state uses non-blocking assignments to avoid update-order races.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign pop_bit = mem[rd_ptr];

endmodule

// File: rtl/activation_backprop.sv
// Backward ReLU mask: records forward derivative bits and applies them in order
// to the gradient stream, widening each surviving gradient to accumulator width.
module activation_backprop
   import activation_backprop_pkg::*;
#(
   parameter int IP_DATA_WIDTH = 32,
   parameter int OP_DATA_WIDTH = 16,
   parameter int DEPTH         = 16
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  af_control                  AF_CONTROL,
   input  logic                       CLEAR,
   input  logic                       FWD_VALID,
   input  logic                       FWD_SIGN,
   output logic                       FWD_READY,
   input  logic                       GRAD_VALID,
   input  logic [OP_DATA_WIDTH-1:0]   GRAD_DATA,
   output logic                       GRAD_READY,
   output logic                       OUT_VALID,
   output logic [IP_DATA_WIDTH-1:0]   OUT_DATA,
   input  logic                       OUT_READY,
   output logic [$clog2(DEPTH+1)-1:0] MASK_COUNT
);

   localparam int WIDTH_DIFFERENCE = IP_DATA_WIDTH - OP_DATA_WIDTH;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic                     push;
   logic                     pop;
   logic                     mask_bit;
   logic [IP_DATA_WIDTH-1:0] widened;
   logic [IP_DATA_WIDTH-1:0] result;

   // Readiness looks only at the current count; no same-cycle lookahead either way.
   assign FWD_READY  = !RST && !CLEAR && (MASK_COUNT != FULL_COUNT);
   assign GRAD_READY = !RST && !CLEAR && (MASK_COUNT != '0) && (!OUT_VALID || OUT_READY);
   assign push       = FWD_VALID && FWD_READY;
   assign pop        = GRAD_VALID && GRAD_READY;

   activation_backprop_mask_fifo #(
      .DEPTH(DEPTH)
   ) mask_fifo (
      .clk      (CLK),
      .rst      (RST),
      .clear    (CLEAR),
      .push     (push),
      .push_bit (af_mask(AF_CONTROL, FWD_SIGN)),
      .pop      (pop),
      .pop_bit  (mask_bit),
      .count    (MASK_COUNT)
   );

   // Zero-filled LSBs undo the forward MSB slice; sign is preserved in the top bits.
   assign widened = IP_DATA_WIDTH'(GRAD_DATA) << WIDTH_DIFFERENCE;
   assign result  = mask_bit ? widened : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
      end else if (CLEAR) begin
         OUT_VALID <= 1'b0;
      end else if (pop) begin
         OUT_VALID <= 1'b1;
         OUT_DATA  <= result;
      end else if (OUT_READY) begin
         OUT_VALID <= 1'b0;
      end
   end

endmodule
